// File: rtl/uart_lite_pkg.sv
// Shared constants for the UART Lite responder: register selects, STAT/CTRL bit
// positions and the AXI response code.
package uart_lite_pkg;

  // Register select taken from address bits [3:2]
  typedef enum logic [1:0] {
    REG_RX   = 2'd0,
    REG_TX   = 2'd1,
    REG_STAT = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_RST_TX   = 0;
  localparam int CTRL_RST_RX   = 1;
  localparam int CTRL_INTR_EN  = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_uart_lite_responder_if.sv
// AXI4-Lite bus bundle (4-bit address, 32-bit data) between the UART buffer
// initiator (master) and the UART Lite responder (slave).
interface axi_uart_lite_responder_if;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  modport master (
    output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
           wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
           wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/uart_lite_fifo.sv
// Synchronous FIFO with first-word-fall-through head; flush has priority over
// push/pop and empties the FIFO at the next edge.
module uart_lite_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // A pop frees the slot, so a push into a full FIFO still lands that cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_uart_lite_responder.sv
// AXI4-Lite responder exposing the UART Lite register map over RX/TX FIFOs.
// Optional interrupt logic is built when UART_LITE_INTR_EN is defined.
module axi_uart_lite_responder
  import uart_lite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_uart_lite_responder_if.slave axi,
  input  logic [7:0]               rx_data,
  input  logic                     rx_strobe,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     interrupt
);
  reg_sel_e   rd_sel, wr_sel;
  logic       ar_hs, wr_hs, rvalid_q, bvalid_q;
  logic [7:0] rdata_q, rd_mux, stat;
  logic       rx_empty, rx_full, rx_pop, rx_flush;
  logic [7:0] rx_head;
  logic       tx_empty, tx_full, tx_push, tx_flush;
  logic       ctrl_wr, stat_rd, overrun_set, overrun, ien;
  logic       unused_bits;

  assign rd_sel = reg_sel_e'(axi.araddr[3:2]);
  assign wr_sel = reg_sel_e'(axi.awaddr[3:2]);

  assign axi.arready = ~rvalid_q;
  assign ar_hs       = axi.arvalid & ~rvalid_q;
  assign wr_hs       = axi.awvalid & axi.wvalid & ~bvalid_q;
  assign axi.awready = wr_hs;
  assign axi.wready  = wr_hs;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = {24'b0, rdata_q};
  assign axi.rresp   = RESP_OKAY;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = RESP_OKAY;

  assign rx_pop   = ar_hs & (rd_sel == REG_RX);
  assign stat_rd  = ar_hs & (rd_sel == REG_STAT);
  assign ctrl_wr  = wr_hs & (wr_sel == REG_CTRL) & axi.wstrb[0];
  assign tx_push  = wr_hs & (wr_sel == REG_TX) & axi.wstrb[0];
  assign tx_flush = ctrl_wr & axi.wdata[CTRL_RST_TX];
  assign rx_flush = ctrl_wr & axi.wdata[CTRL_RST_RX];
  // A full FIFO being read this cycle makes room, so that strobe is not an overrun
  assign overrun_set = rx_strobe & rx_full & ~rx_pop;

  assign tx_valid = ~tx_empty;

  assign unused_bits = ^{axi.arprot, axi.awprot, axi.araddr[1:0], axi.awaddr[1:0],
                         axi.wdata[31:8], axi.wstrb[3:1]};

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk, .rstn, .push(rx_strobe), .din(rx_data), .pop(rx_pop), .flush(rx_flush),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk, .rstn, .push(tx_push), .din(axi.wdata[7:0]), .pop(tx_ready), .flush(tx_flush),
    .head(tx_data), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    stat                = '0;
    stat[STAT_RX_VALID] = ~rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_INTR_EN]  = ien;
    stat[STAT_OVERRUN]  = overrun;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_RX:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_STAT: rd_mux = stat;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)            bvalid_q <= 1'b0;
    else if (wr_hs)       bvalid_q <= 1'b1;
    else if (axi.bready)  bvalid_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) overrun <= 1'b0;
    else       overrun <= overrun_set | (overrun & ~stat_rd);
  end

`ifdef UART_LITE_INTR_EN
  logic rx_empty_q, tx_empty_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ien        <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      if (ctrl_wr) ien <= axi.wdata[CTRL_INTR_EN];
      rx_empty_q <= rx_empty;
      tx_empty_q <= tx_empty;
    end
  end

  // Fires in the first cycle the new FIFO state is visible
  assign interrupt = ien & ((rx_empty_q & ~rx_empty) | (~tx_empty_q & tx_empty));
`else
  assign ien       = 1'b0;
  assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_axi_uart_lite_responder.sv
// Randomized self-checking bench for axi_uart_lite_responder against a queue
// model of the register map.
module tb_axi_uart_lite_responder;
  localparam int DEPTH = 16;
`ifdef UART_LITE_INTR_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [7:0] rx_data, tx_data;
  logic rx_strobe, tx_valid, tx_ready, interrupt;

  always #5 clk = ~clk;

  axi_uart_lite_responder_if axi();

  axi_uart_lite_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .axi(axi.slave),
    .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .interrupt(interrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit m_ovr, m_ien;

  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    s = '0;
    s[0] = (rx_q.size() != 0);
    s[1] = (rx_q.size() == DEPTH);
    s[2] = (tx_q.size() == 0);
    s[3] = (tx_q.size() == DEPTH);
    s[4] = INTR & m_ien;
    s[5] = m_ovr;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    axi.araddr = a; axi.arvalid = 1'b1; #1;
    n = 0;
    while (!axi.arready && n < 20) begin tick(); n++; end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    n_checks++;
    if (axi.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_latency addr=%h rvalid=%b required 1", a, axi.rvalid);
    end
    n = 0;
    while (!axi.rvalid && n < 20) begin tick(); n++; end
    d = axi.rdata;
    tick();
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; #1;
    n = 0;
    while (!axi.awready && n < 20) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n_checks++;
    if (axi.bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_latency addr=%h bvalid=%b required 1", a, axi.bvalid);
    end
    tick();
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0;
    axi.arvalid = 0; axi.araddr = 0; axi.arprot = 0; axi.rready = 1;
    axi.awvalid = 0; axi.awaddr = 0; axi.awprot = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.bready = 1;
    rx_data = 0; rx_strobe = 0; tx_ready = 0;
    repeat (3) tick();
    n_checks++;
    if ({axi.rvalid, axi.bvalid, axi.arready, axi.awready, axi.wready, tx_valid, interrupt} !== 7'b0010000
        || axi.rdata !== 32'h0 || axi.rresp !== 2'b00 || axi.bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs rv=%b bv=%b arr=%b awr=%b wr=%b txv=%b irq=%b rdata=%h required 0 0 1 0 0 0 0 0",
               axi.rvalid, axi.bvalid, axi.arready, axi.awready, axi.wready, tx_valid, interrupt, axi.rdata);
    end
    rstn = 1'b1;
    rx_q.delete(); tx_q.delete(); m_ovr = 0; m_ien = 0;
    tick();
    axi_read(4'h8, d);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL reset_stat got=%h required 04", d); end
  endtask

  task automatic drain_tx(input string tag);
    tx_ready = 1'b1;
    while (tx_q.size() != 0) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
        n_fail++;
        $display("FAIL %s_drain got v=%b d=%h required v=1 d=%h", tag, tx_valid, tx_data, tx_q[0]);
      end
      void'(tx_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL %s_empty tx_valid=%b required 0", tag, tx_valid); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int n;
    logic [7:0] b;
    tx_ready = 1'b0;
    n = 2 + $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'($urandom);
      axi_write(4'h4, {24'($urandom), b}, 4'hF);
      tx_q.push_back(b);
    end
    axi_write(4'h4, 32'h77, 4'hE);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      n_fail++; $display("FAIL tx_head v=%b d=%h required v=1 d=41", tx_valid, tx_data);
    end
    drain_tx("tx");
    axi_read(4'h8, d);
    n_checks++;
    if (d !== model_stat() || d !== 32'h04) begin n_fail++; $display("FAIL tx_stat got=%h required 04", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 1; i <= DEPTH + 1; i++) rx_pulse(8'(i));
    axi_read(4'h8, d);
    n_checks++;
    if (d !== model_stat() || d !== 32'h27) begin n_fail++; $display("FAIL ovr_stat got=%h required 27", d); end
    m_ovr = 1'b0;
    axi_read(4'h8, d);
    n_checks++;
    if (d !== 32'h07) begin n_fail++; $display("FAIL ovr_clear got=%h required 07", d); end
    for (int i = 0; i <= DEPTH; i++) begin
      e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
      axi_read(4'h0, d);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL rx_read[%0d] got=%h required %h", i, d, e); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] d;
    logic [7:0] nb, e;
    for (int i = 0; i < DEPTH; i++) rx_pulse(8'($urandom));
    nb = 8'($urandom);
    e  = rx_q.pop_front();
    rx_q.push_back(nb);
    axi.araddr = 4'h0; axi.arvalid = 1'b1;
    rx_data = nb; rx_strobe = 1'b1;
    tick();
    axi.arvalid = 1'b0; rx_strobe = 1'b0;
    n_checks++;
    if (axi.rvalid !== 1'b1 || axi.rdata !== {24'h0, e}) begin
      n_fail++; $display("FAIL pp_read got v=%b d=%h required v=1 d=%h", axi.rvalid, axi.rdata, e);
    end
    tick();
    axi_read(4'h8, d);
    n_checks++;
    if (d !== model_stat() || d !== 32'h07) begin n_fail++; $display("FAIL pp_stat got=%h required 07", d); end
    for (int i = 0; i < DEPTH; i++) begin
      e = rx_q.pop_front();
      axi_read(4'h0, d);
      n_checks++;
      if (d !== {24'h0, e}) begin n_fail++; $display("FAIL pp_order[%0d] got=%h required %h", i, d, e); end
    end
  endtask

  task automatic test_intr();
    logic [31:0] d;
    axi_write(4'hC, 32'h13, 4'hF);
    rx_q.delete(); tx_q.delete(); m_ien = 1'b1;
    rx_data = 8'h55; rx_strobe = 1'b1; #1;
    n_checks++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b required 0", interrupt); end
    tick();
    rx_strobe = 1'b0;
    rx_q.push_back(8'h55);
    n_checks++;
    if (interrupt !== INTR) begin n_fail++; $display("FAIL irq_rx_pulse got=%b required %b", interrupt, INTR); end
    tick();
    n_checks++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_rx_width got=%b required 0", interrupt); end
    axi_read(4'h8, d);
    n_checks++;
    if (d !== model_stat()) begin n_fail++; $display("FAIL irq_stat got=%h required %h", d, model_stat()); end
    axi_write(4'h4, 32'hC3, 4'h1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_checks++;
    if (interrupt !== INTR || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL irq_tx_pulse got=%b txv=%b required %b 0", interrupt, tx_valid, INTR);
    end
    axi_read(4'h0, d);
    void'(rx_q.pop_front());
    axi_write(4'hC, 32'h00, 4'hF);
    m_ien = 1'b0;
  endtask

  task automatic test_backpressure();
    axi.bready = 1'b0;
    axi_write(4'h4, 32'hA5, 4'hF);
    tx_q.push_back(8'hA5);
    axi.awaddr = 4'h4; axi.wdata = 32'h5A; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (axi.awready !== 1'b0 || axi.wready !== 1'b0 || axi.bvalid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d] awr=%b wr=%b bv=%b required 0 0 1", i, axi.awready, axi.wready, axi.bvalid);
      end
      @(posedge clk); #2;
    end
    axi.bready = 1'b1;
    tick();
    n_checks++;
    if (axi.awready !== 1'b1 || axi.wready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release awr=%b wr=%b required 1 1", axi.awready, axi.wready);
    end
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tx_q.push_back(8'h5A);
    tick();
    drain_tx("bp");
  endtask

  task automatic test_back_to_back();
    int hs;
    hs = 0;
    axi.araddr = 4'h8; axi.arvalid = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      if (axi.arready) hs++;
      tick();
    end
    axi.arvalid = 1'b0;
    m_ovr = 1'b0;
    tick(); tick();
    n_checks++;
    if (hs !== 4) begin n_fail++; $display("FAIL b2b_rate got=%0d required 4", hs); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [3:0] s;
    logic [7:0] b;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 6))
        0: rx_pulse(8'($urandom));
        1: begin
          b = 8'($urandom); s = 4'($urandom);
          axi_write(4'h4, {24'($urandom), b}, s);
          if (s[0] && tx_q.size() < DEPTH) tx_q.push_back(b);
        end
        2: begin
          e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
          axi_read(4'h0, d);
          n_checks++;
          if (d !== e) begin n_fail++; $display("FAIL rnd_rx[%0d] got=%h required %h", i, d, e); end
        end
        3: begin
          e = model_stat();
          axi_read(4'h8, d);
          m_ovr = 1'b0;
          n_checks++;
          if (d !== e) begin n_fail++; $display("FAIL rnd_stat[%0d] got=%h required %h", i, d, e); end
        end
        4: begin
          n_checks++;
          if (tx_valid !== (tx_q.size() != 0) || (tx_q.size() != 0 && tx_data !== tx_q[0])) begin
            n_fail++; $display("FAIL rnd_tx[%0d] got v=%b d=%h required v=%b", i, tx_valid, tx_data, tx_q.size() != 0);
          end
          tx_ready = 1'b1; tick(); tx_ready = 1'b0;
          if (tx_q.size() != 0) void'(tx_q.pop_front());
        end
        5: axi_write(($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, $urandom, 4'hF);
        default: begin
          axi_read(($urandom_range(0, 1) != 0) ? 4'hC : 4'h4, d);
          n_checks++;
          if (d !== 32'h0) begin n_fail++; $display("FAIL rnd_wo[%0d] got=%h required 0", i, d); end
        end
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d assertions", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tx();
    test_rx_overrun();
    test_full_pushpop();
    test_intr();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
